// File: rtl/sram_port_ctrl_pkg.sv
// sram_cfg_pkg: shared definitions for the SRAM port sequencer.
//   - width-config encodings CFG_X32..CFG_X1 (110/111 are illegal)
//   - cfg_legal / cfg_width / cfg_lane_bits / cfg_replicate helpers
//   - FSM state type used by sram_port_ctrl
package sram_cfg_pkg;

  localparam logic [2:0] CFG_X32 = 3'd0;
  localparam logic [2:0] CFG_X16 = 3'd1;
  localparam logic [2:0] CFG_X8  = 3'd2;
  localparam logic [2:0] CFG_X4  = 3'd3;
  localparam logic [2:0] CFG_X2  = 3'd4;
  localparam logic [2:0] CFG_X1  = 3'd5;

  typedef enum logic [2:0] {IDLE, WR, RD, RWAIT, RESP} state_t;

  function automatic logic cfg_legal(input logic [2:0] cfg);
    return cfg <= CFG_X1;
  endfunction

  // Lane width W in bits; 0 for illegal encodings.
  function automatic logic [5:0] cfg_width(input logic [2:0] cfg);
    return cfg_legal(cfg) ? (6'd32 >> cfg) : 6'd0;
  endfunction

  // log2 of the lane count L = 32/W.
  function automatic logic [2:0] cfg_lane_bits(input logic [2:0] cfg);
    return cfg_legal(cfg) ? cfg : 3'd0;
  endfunction

  // Repeat data[W-1:0] across all 32 bits: bit i takes data[i mod W].
  function automatic logic [31:0] cfg_replicate(input logic [31:0] data,
                                                input logic [2:0]  cfg);
    logic [4:0]  wm;
    logic [31:0] r;
    wm = 5'(cfg_width(cfg) - 6'd1);
    for (int i = 0; i < 32; i++) r[i] = data[5'(i) & wm];
    return r;
  endfunction

endpackage

// File: rtl/sram_port_ctrl_if.sv
// sram_port_if: request/response handshake plus SRAM macro and mask
// generator signals for sram_port_ctrl.
//   slave  - controller view (accepts requests, drives macro/mask side)
//   master - environment view (issues requests, returns row read data)
interface sram_port_if #(parameter int ROW_AW = 10);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [14:0]       req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic [ROW_AW-1:0] sram_row;
  logic              sram_we;
  logic              sram_re;
  logic [31:0]       sram_wdata;
  logic [31:0]       sram_rdata;
  logic [4:0]        mask_addr;
  logic [2:0]        mask_cfg;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready, sram_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           sram_row, sram_we, sram_re, sram_wdata, mask_addr, mask_cfg
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready, sram_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
           sram_row, sram_we, sram_re, sram_wdata, mask_addr, mask_cfg
  );
endinterface

// File: rtl/sram_port_ctrl_lane_extract.sv
// sram_lane_extract: pure combinational lane select.
//   rdata - full 32-bit row read data
//   lane  - lane index (already reduced modulo lane count)
//   cfg   - width config
//   data  - lane bits right-aligned, upper bits zero; 0 for illegal cfg
module sram_lane_extract
  import sram_cfg_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [4:0]  lane,
  input  logic [2:0]  cfg,
  output logic [31:0] data
);

  logic [2:0]  lb;
  logic [5:0]  w;
  logic [4:0]  shamt;
  logic [31:0] mask;

  always_comb begin
    lb    = cfg_lane_bits(cfg);
    w     = cfg_width(cfg);
    // lane*W == lane << log2(W) == lane << (5 - log2(L))
    shamt = lane << (3'd5 - lb);
    mask  = (w == 6'd0) ? 32'd0 : (32'hFFFF_FFFF >> (6'd32 - w));
    data  = (rdata >> shamt) & mask;
  end

endmodule

// File: rtl/sram_port_ctrl.sv
// sram_port_ctrl: request-side sequencer for the width-configurable SRAM bank.
// Splits a narrow word address into row/lane, replicates write data across
// lanes, strobes the macro and returns the addressed lane on reads.
// Ports:
//   clk, rst - clock, asynchronous active-high reset
//   cfg      - width config, sampled only when a request is accepted
//   bus      - sram_port_if.slave (request, response, macro, mask signals)
// Optional build macro SRAM_PORT_PERF_CNT_EN adds saturating counters
// perf_rd_cnt, perf_wr_cnt, perf_err_cnt.
//
// state | meaning
// IDLE  | ready for a request
// WR    | sram_we pulse, back to IDLE
// RD    | sram_re pulse, load latency timer
// RWAIT | count down; capture lane at terminal count
// RESP  | response held until rsp_ready
module sram_port_ctrl
  import sram_cfg_pkg::*;
#(
  parameter int READ_LAT = 1,
  parameter int ROW_AW   = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  cfg,
  sram_port_if.slave  bus
`ifdef SRAM_PORT_PERF_CNT_EN
  ,
  output logic [31:0] perf_rd_cnt,
  output logic [31:0] perf_wr_cnt,
  output logic [15:0] perf_err_cnt
`endif
);

  localparam logic [1:0] LAT_LOAD = 2'(READ_LAT - 1);

  state_t      state, state_nx;
  logic        accept;
  logic [1:0]  lat_cnt;
  logic [2:0]  lb;
  logic [4:0]  lane_mask;
  logic [31:0] lane_data;

  assign accept = bus.req_valid && (state == IDLE);
  assign lb     = cfg_lane_bits(cfg);
  // 5-bit wrap makes x1 (lb=5) yield 31.
  assign lane_mask = (5'd1 << lb) - 5'd1;

  sram_lane_extract u_extract (
    .rdata (bus.sram_rdata),
    .lane  (bus.mask_addr),
    .cfg   (bus.mask_cfg),
    .data  (lane_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx      = state;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.sram_we   = 1'b0;
    bus.sram_re   = 1'b0;
    case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          if (!cfg_legal(cfg)) state_nx = RESP;
          else if (bus.req_we) state_nx = WR;
          else                 state_nx = RD;
        end
      end
      WR: begin
        bus.sram_we = 1'b1;
        state_nx    = IDLE;
      end
      RD: begin
        bus.sram_re = 1'b1;
        state_nx    = RWAIT;
      end
      RWAIT: begin
        if (lat_cnt == 2'd0) state_nx = RESP;
      end
      RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.sram_row   <= '0;
      bus.sram_wdata <= '0;
      bus.mask_addr  <= '0;
      bus.mask_cfg   <= '0;
      bus.rsp_rdata  <= '0;
      bus.rsp_err    <= 1'b0;
      lat_cnt        <= '0;
    end else begin
      if (accept) begin
        bus.sram_row   <= ROW_AW'(bus.req_addr >> lb);
        bus.mask_addr  <= bus.req_addr[4:0] & lane_mask;
        bus.mask_cfg   <= cfg;
        bus.sram_wdata <= cfg_replicate(bus.req_wdata, cfg);
        if (!cfg_legal(cfg)) begin
          bus.rsp_err   <= 1'b1;
          bus.rsp_rdata <= '0;
        end
      end
      if (state == RD) lat_cnt <= LAT_LOAD;
      else if (state == RWAIT && lat_cnt != 2'd0) lat_cnt <= lat_cnt - 2'd1;
      // Terminal count coincides with the cycle sram_rdata is valid.
      if (state == RWAIT && lat_cnt == 2'd0) bus.rsp_rdata <= lane_data;
      if (state == RESP && bus.rsp_ready) bus.rsp_err <= 1'b0;
    end
  end

`ifdef SRAM_PORT_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_rd_cnt  <= '0;
      perf_wr_cnt  <= '0;
      perf_err_cnt <= '0;
    end else if (accept) begin
      if (!cfg_legal(cfg)) begin
        if (perf_err_cnt != '1) perf_err_cnt <= perf_err_cnt + 16'd1;
      end else if (bus.req_we) begin
        if (perf_wr_cnt != '1) perf_wr_cnt <= perf_wr_cnt + 32'd1;
      end else begin
        if (perf_rd_cnt != '1) perf_rd_cnt <= perf_rd_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_sram_port_ctrl.sv
// Self-checking bench for sram_port_ctrl (READ_LAT=2, default build).
module tb_sram_port_ctrl;
  localparam int READ_LAT = 2;
  localparam int ROW_AW   = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  cfg = 3'd0;
  logic [31:0] rd_word = 32'd0;
  logic [3:0]  re_pipe = 4'd0;
  logic        both_seen = 1'b0;
  int          checks = 0;
  int          errors = 0;

  sram_port_if #(.ROW_AW(ROW_AW)) bus ();

  sram_port_ctrl #(.READ_LAT(READ_LAT), .ROW_AW(ROW_AW)) dut (
    .clk (clk),
    .rst (rst),
    .cfg (cfg),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Macro model: row data is valid only READ_LAT cycles after the sram_re
  // cycle; otherwise the inverted word is presented.
  always @(posedge clk or posedge rst) begin
    if (rst) re_pipe <= 4'd0;
    else     re_pipe <= {re_pipe[2:0], bus.sram_re};
  end
  assign bus.sram_rdata = re_pipe[READ_LAT-1] ? rd_word : ~rd_word;

  always @(negedge clk) if (bus.sram_we && bus.sram_re) both_seen <= 1'b1;

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Full transaction with reference computed from widths/lanes arithmetic.
  task automatic run_txn(input logic we, input logic [2:0] c, input logic [14:0] addr,
                         input logic [31:0] wd, input logic [31:0] rw, input int hold);
    int w, l, lane, row, n;
    longint unsigned fld, rep, ext, rwl;
    logic [31:0] held;
    logic legal;
    legal = (c <= 3'd5);
    w = legal ? (32 >> c) : 32;
    l = 32 / w;
    lane = int'(addr) % l;
    row = (int'(addr) / l) % 1024;
    fld = longint'(wd) % (64'd1 << w);
    rep = 0;
    for (int k = 0; k < l; k++) rep += fld << (k * w);
    rwl = longint'(rw);
    ext = (rwl >> (lane * w)) % (64'd1 << w);

    cfg = c; rd_word = rw;
    bus.req_we = we; bus.req_addr = addr; bus.req_wdata = wd;
    bus.req_valid = 1'b1; bus.rsp_ready = 1'b0;
    check("req_ready_idle", 32'(bus.req_ready), 32'd1);
    tick();
    bus.req_valid = 1'b0;
    bus.req_addr = 15'($urandom);
    cfg = 3'($urandom);

    if (!legal) begin
      check("err_valid", 32'(bus.rsp_valid), 32'd1);
      check("err_flag", 32'(bus.rsp_err), 32'd1);
      check("err_rdata", bus.rsp_rdata, 32'd0);
      check("err_no_strobe", {30'd0, bus.sram_we, bus.sram_re}, 32'd0);
    end else if (we) begin
      check("wr_we", {30'd0, bus.sram_we, bus.sram_re}, 32'd2);
      check("wr_row", 32'(bus.sram_row), 32'(row));
      check("wr_mask_addr", 32'(bus.mask_addr), 32'(lane));
      check("wr_mask_cfg", 32'(bus.mask_cfg), 32'(c));
      check("wr_wdata", bus.sram_wdata, 32'(rep));
      tick();
      check("wr_we_done", 32'(bus.sram_we), 32'd0);
      check("wr_ready_after", 32'(bus.req_ready), 32'd1);
      check("wr_no_rsp", 32'(bus.rsp_valid), 32'd0);
      return;
    end else begin
      check("rd_re", {30'd0, bus.sram_we, bus.sram_re}, 32'd1);
      check("rd_row", 32'(bus.sram_row), 32'(row));
      check("rd_mask_addr", 32'(bus.mask_addr), 32'(lane));
      check("rd_mask_cfg", 32'(bus.mask_cfg), 32'(c));
      n = 1;
      while (bus.rsp_valid !== 1'b1 && n < 20) begin
        tick();
        n++;
        if (bus.rsp_valid !== 1'b1) begin
          check("rd_re_single", 32'(bus.sram_re), 32'd0);
          check("rd_row_stable", 32'(bus.sram_row), 32'(row));
        end
      end
      check("rd_latency", 32'(n), 32'(READ_LAT + 2));
      check("rd_data", bus.rsp_rdata, 32'(ext));
      check("rd_err", 32'(bus.rsp_err), 32'd0);
    end

    check("rsp_blocks_req", 32'(bus.req_ready), 32'd0);
    held = bus.rsp_rdata;
    for (int i = 0; i < hold; i++) begin
      tick();
      check("bp_valid", 32'(bus.rsp_valid), 32'd1);
      check("bp_rdata", bus.rsp_rdata, held);
      check("bp_ready", 32'(bus.req_ready), 32'd0);
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    check("rsp_cleared", {30'd0, bus.rsp_valid, bus.rsp_err}, 32'd0);
    check("ready_after_rsp", 32'(bus.req_ready), 32'd1);
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0;
    bus.req_wdata = '0; bus.rsp_ready = 1'b0;
    #3;
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("rst_rsp", {29'd0, bus.rsp_valid, bus.rsp_err, bus.sram_we}, 32'd0);
    check("rst_re", 32'(bus.sram_re), 32'd0);
    check("rst_rdata", bus.rsp_rdata, 32'd0);
    check("rst_row", 32'(bus.sram_row), 32'd0);
    check("rst_wdata", bus.sram_wdata, 32'd0);
    check("rst_mask", {24'd0, bus.mask_addr, bus.mask_cfg}, 32'd0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // Directed cases.
    run_txn(1'b1, 3'b010, 15'h0013, 32'h0000_00A5, 32'd0, 0);
    run_txn(1'b0, 3'b011, 15'h0025, 32'd0, 32'h7654_3210, 0);
    run_txn(1'b0, 3'b000, 15'h03FF, 32'd0, 32'hDEAD_BEEF, 1);
    run_txn(1'b0, 3'b101, 15'h7FFF, 32'd0, 32'h8000_0000, 0);
    run_txn(1'b0, 3'b111, 15'h0123, 32'd0, 32'h1234_5678, 2);
    run_txn(1'b0, 3'b110, 15'h0456, 32'd0, 32'h1234_5678, 0);
    run_txn(1'b0, 3'b001, 15'h0801, 32'd0, 32'hCAFE_F00D, 5);
    run_txn(1'b1, 3'b101, 15'h7FE1, 32'h0000_0001, 32'd0, 0);

    // Randomized transactions.
    for (int t = 0; t < 40; t++) begin
      run_txn(1'($urandom), 3'($urandom), 15'($urandom), $urandom, $urandom,
              int'($urandom_range(0, 3)));
    end

    // Reset in the middle of a read.
    cfg = 3'b000; rd_word = 32'h5A5A_1234;
    bus.req_we = 1'b0; bus.req_addr = 15'h0155; bus.req_valid = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    check("midrst_ready", 32'(bus.req_ready), 32'd1);
    check("midrst_strobes", {29'd0, bus.rsp_valid, bus.sram_we, bus.sram_re}, 32'd0);
    check("midrst_row", 32'(bus.sram_row), 32'd0);
    check("midrst_rdata", bus.rsp_rdata, 32'd0);
    check("midrst_mask", {24'd0, bus.mask_addr, bus.mask_cfg}, 32'd0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("postrst_quiet", {30'd0, bus.rsp_valid, bus.sram_we}, 32'd0);
    end

    run_txn(1'b0, 3'b100, 15'h0007, 32'd0, 32'h9ABC_DEF0, 0);
    check("we_re_exclusive", 32'(both_seen), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sram_port_ctrl.md
Name: sram_port_ctrl

Overview:
Request-side sequencer for the width-configurable SRAM bank (1k x 32 down to 32k x 1). It sits directly upstream of the bit-line write-mask generator.
- Accepts narrow read/write requests over a valid/ready handshake.
- Splits the word address into a 10-bit row address and a 5-bit lane index.
- Replicates write data across all lanes and drives the mask generator's addr/config inputs.
- On reads, waits out the macro latency, then extracts and right-aligns the addressed lane.

Parameters:
READ_LAT, 1, cycles from sram_re assertion to sram_rdata valid (legal 1..4)
ROW_AW, 10, SRAM row address width (1k rows)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
cfg  in  3  width config: 000 x32, 001 x16, 010 x8, 011 x4, 100 x2, 101 x1; 110/111 illegal
req_valid  in  1  request valid
req_ready  out  1  request accepted when valid&&ready
req_we  in  1  1 = write, 0 = read
req_addr  in  15  word address in current width's address space
req_wdata  in  32  write data, right-aligned, width W
rsp_valid  out  1  read response / error valid
rsp_ready  in  1  response accepted when valid&&ready
rsp_rdata  out  32  read data right-aligned, upper bits zero
rsp_err  out  1  request used illegal cfg
sram_row  out  ROW_AW  row address to macro
sram_we  out  1  write strobe, one cycle
sram_re  out  1  read strobe, one cycle
sram_wdata  out  32  lane-replicated write data
sram_rdata  in  32  row read data
mask_addr  out  5  lane index to mask generator
mask_cfg  out  3  config to mask generator

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high on port rst.
- Width and lanes: W = 32 >> cfg; lanes L = 32/W.
  - lane = req_addr & (L-1).
  - row = req_addr >> log2(L), truncated to ROW_AW.
  - Lane k occupies row bits [k*W +: W].
  - Address bits above row+lane are ignored.
- Reset values: FSM=IDLE; req_ready=1; rsp_valid=0; rsp_err=0; rsp_rdata=0; sram_we=0; sram_re=0; sram_row=0; sram_wdata=0; mask_addr=0; mask_cfg=0.
- Accept: in IDLE, req_ready=1. On handshake, latch cfg, lane, row, we and replicated data ({L{wdata[W-1:0]}}).
  - cfg is sampled only at accept; cfg changes mid-operation have no effect.
- FSM states:
  - IDLE:
    - accept with illegal cfg -> RESP, with rsp_err=1, rsp_rdata=0, no SRAM access.
    - accept write -> WR.
    - accept read -> RD.
  - WR: sram_we=1 for exactly one cycle, then -> IDLE. Writes produce no response. The earliest next accept is the cycle after WR.
  - RD: sram_re=1 for one cycle; counter loads READ_LAT-1 -> RWAIT (or straight to capture if READ_LAT=1).
  - RWAIT: decrement counter. At the cycle sram_rdata is valid, capture (sram_rdata >> lane*W) & ((1<<W)-1) into rsp_rdata -> RESP.
  - RESP: rsp_valid=1, held stable until rsp_ready. Clear rsp_valid/rsp_err on handshake -> IDLE.
- Latency:
  - Read: accept at cycle 0; sram_re at cycle 1; rsp_valid at cycle 1+READ_LAT+1.
  - Write: accept at cycle 0; sram_we at cycle 1.
- Strobe stability: sram_row, mask_addr, mask_cfg and sram_wdata are registered and stable throughout WR/RD/RWAIT. sram_we and sram_re are never both high.
- Back-pressure: while rsp_ready=0 in RESP, req_ready=0. There is no second outstanding request.
- Reset mid-operation: all state returns to reset values immediately (asynchronous). Any in-flight read is dropped; no spurious sram_we.

Optional Feature:
SRAM_PORT_PERF_CNT_EN
- Defined: adds outputs perf_rd_cnt[31:0], perf_wr_cnt[31:0] and perf_err_cnt[15:0].
  - Each counter increments on the corresponding accept and saturates at all-ones.
  - Each counter clears on rst.
- Undefined: no counters or ports; the rest of the behaviour is identical.

Decomposition:
- Shared package sram_cfg_pkg:
  - cfg encodings (CFG_X32..CFG_X1);
  - function cfg_width(cfg);
  - function cfg_lane_bits(cfg);
  - FSM state typedef {IDLE, WR, RD, RWAIT, RESP}.
- One natural sub-module: sram_lane_extract, a combinational shift/mask of sram_rdata by lane and cfg. Instantiated once and reusable by the verification model.

Test Plan:
- Write lane: cfg=010, write addr=0x0013, wdata=0xA5 -> sram_row=0x004, mask_addr=3, sram_wdata=0xA5A5A5A5, sram_we single pulse at cycle 1.
- Read extract: cfg=011, read addr=0x0025, READ_LAT=2, sram_rdata=0x76543210 -> sram_row=0x004, rsp_rdata=0x00000005, rsp_valid at cycle 4.
- Widths extremes:
  - cfg=000, read addr=0x3FF, sram_rdata=0xDEADBEEF -> sram_row=0x3FF, rsp_rdata=0xDEADBEEF.
  - cfg=101, read addr=0x7FFF, sram_rdata bit31=1 -> sram_row=0x3FF, mask_addr=31, rsp_rdata=1.
- Illegal cfg: cfg=111, req_valid -> rsp_valid with rsp_err=1, rsp_rdata=0; sram_we/sram_re never asserted.
- Back-pressure: hold rsp_ready=0 for 5 cycles -> rsp_valid and rsp_rdata stable, req_ready=0. Release -> req_ready=1 next cycle.
- Reset mid-read: assert rst during RWAIT -> all outputs at reset values same cycle; no rsp_valid after release.
